conv_result_serializer: RTL and testbench

- Downstream stage of the combinational convolution block.
- Captures one packed result frame of LEN1+LEN2-1 signed 2N-bit samples in a single cycle.
- Requantises each sample to N bits with a rounded arithmetic right shift.
- Streams the samples out one per accepted beat, index 0 first, on a valid/ready interface with a last flag.

---
 rtl/conv_pkg.sv | 61 ++++++
 rtl/conv_result_serializer_if.sv | 38 +++
 rtl/conv_requant.sv | 31 +++
 rtl/conv_result_serializer.sv | 119 +++++++++++
 tb/tb_conv_result_serializer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the convolution result path
// Purpose: result-length/index-width derivation, serializer state enum and the
//          round-shift + saturate/wrap function shared with conv_input_packer.
// Ports:   none (package).
// Config:  none; saturation is selected per call through the saturate argument.
package conv_pkg;

  // Working width for requantisation; holds a sign-extended 2N-bit word plus
  // the rounding carry for any N up to 31.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             sat;
  } requant_t;

  function automatic int len_out_of(input int len1, input int len2);
    return len1 + len2 - 1;
  endfunction

  function automatic int idx_w_of(input int len_out);
    return (len_out > 1) ? $clog2(len_out) : 1;
  endfunction

  // Round half toward +inf, arithmetic shift, then optionally clamp to the
  // signed n-bit range. Without clamping the caller keeps the low n bits.
  function automatic requant_t round_shift(input logic signed [MAX_W-1:0] x,
                                           input int n,
                                           input int shift,
                                           input bit saturate);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    requant_t res;
    one = 1;
    r = x;
    if (shift > 0) r = r + (one <<< (shift - 1));
    r = r >>> shift;
    max_v = (one <<< (n - 1)) - one;
    min_v = -(one <<< (n - 1));
    res.value = r;
    res.sat = 1'b0;
    if (saturate) begin
      if (r > max_v) begin
        res.value = max_v;
        res.sat = 1'b1;
      end else if (r < min_v) begin
        res.value = min_v;
        res.sat = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_result_serializer_if.sv
// rtl/conv_result_serializer_if.sv - load/stream bus of the result serializer
// Purpose: bundles frame load handshake, output stream and flush.
// Ports:   frame_in/load_valid/load_ready (frame load), out_data/out_valid/
//          out_ready/out_last (sample stream), flush (abort),
//          sat_flag only when CONV_SAT_EN is defined.
// Modports: master = frame producer / stream consumer, slave = serializer.
interface conv_result_serializer_if #(
  parameter int N       = 16,
  parameter int LEN_OUT = 52
);
  logic [LEN_OUT*2*N-1:0] frame_in;
  logic                   load_valid;
  logic                   load_ready;
  logic [N-1:0]           out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   flush;
`ifdef CONV_SAT_EN
  logic                   sat_flag;
`endif

  modport master (
    output frame_in, load_valid, out_ready, flush,
    input  load_ready, out_data, out_valid, out_last
`ifdef CONV_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  frame_in, load_valid, out_ready, flush,
    output load_ready, out_data, out_valid, out_last
`ifdef CONV_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - combinational requantiser for one 2N-bit result word
// Purpose: rounded arithmetic right shift by SHIFT, narrowed to N bits;
//          saturates when CONV_SAT_EN is defined, wraps otherwise.
// Ports:   word (in, 2N), result (out, N), sat (out, 1: sample clipped).
module conv_requant
  import conv_pkg::*;
#(
  parameter int N     = 16,
  parameter int SHIFT = 8
) (
  input  logic [2*N-1:0] word,
  output logic [N-1:0]   result,
  output logic           sat
);
`ifdef CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  requant_t rq;
  logic     unused_hi;

  always_comb begin
    rq = round_shift({{(MAX_W-2*N){word[2*N-1]}}, word}, N, SHIFT, SAT_EN);
  end

  assign result    = rq.value[N-1:0];
  assign sat       = rq.sat;
  assign unused_hi = ^rq.value[MAX_W-1:N];
endmodule

// File: rtl/conv_result_serializer.sv
// rtl/conv_result_serializer.sv - captures a convolution frame and streams it
// Purpose: latches LEN1+LEN2-1 signed 2N-bit words in one cycle, then emits
//          requantised N-bit samples index 0 first with out_last on the final.
// Ports:   clk, rst (sync active-high), bus (conv_result_serializer_if.slave).
// Config:  CONV_SAT_EN adds saturation and the registered bus.sat_flag.
module conv_result_serializer
  import conv_pkg::*;
#(
  parameter int N     = 16,
  parameter int LEN1  = 3,
  parameter int LEN2  = 50,
  parameter int SHIFT = 8
) (
  input logic                    clk,
  input logic                    rst,
  conv_result_serializer_if.slave bus
);
  localparam int             LEN_OUT  = len_out_of(LEN1, LEN2);
  localparam int             IDXW     = idx_w_of(LEN_OUT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN_OUT - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d, nxt_idx;
  logic [2*N-1:0]   frame_q [LEN_OUT];
  logic [N-1:0]     data_q, data_d;
  logic             last_q, last_d;
  logic             sat_q, sat_d;
  logic             capture;
  logic [2*N-1:0]   sel_word;
  logic [N-1:0]     rq_result;
  logic             rq_sat;

  // Output register is loaded one step ahead: on capture from frame_in word 0,
  // on each accepted beat from the following stored word.
  assign nxt_idx = idx_q + 1'b1;

  always_comb begin
    sel_word = '0;
    if (state_q == IDLE) sel_word = bus.frame_in[0 +: 2*N];
    else if (int'(nxt_idx) < LEN_OUT) sel_word = frame_q[nxt_idx];
  end

  conv_requant #(.N(N), .SHIFT(SHIFT)) u_requant (
    .word   (sel_word),
    .result (rq_result),
    .sat    (rq_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    sat_d   = sat_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.load_valid) begin
          state_d = STREAM;
          capture = 1'b1;
          idx_d   = '0;
          data_d  = rq_result;
          last_d  = (LEN_OUT == 1);
          sat_d   = rq_sat;
        end
      end
      STREAM: begin
        if (bus.flush || (bus.out_ready && last_q)) begin
          state_d = IDLE;
          idx_d   = '0;
          data_d  = '0;
          last_d  = 1'b0;
          sat_d   = 1'b0;
        end else if (bus.out_ready) begin
          idx_d  = nxt_idx;
          data_d = rq_result;
          last_d = (nxt_idx == LAST_IDX);
          sat_d  = rq_sat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LEN_OUT; i++) begin
      if (rst) frame_q[i] <= '0;
      else if (capture) frame_q[i] <= bus.frame_in[i*2*N +: 2*N];
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.out_valid  = (state_q == STREAM);
  assign bus.out_data   = data_q;
  assign bus.out_last   = last_q;

`ifdef CONV_SAT_EN
  assign bus.sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif
endmodule

// File: tb/tb_conv_result_serializer.sv
// tb/tb_conv_result_serializer.sv - directed self-checking bench for conv_result_serializer
module tb_conv_result_serializer;
  localparam int N       = 16;
  localparam int LEN_OUT = 52;
  localparam int FW      = LEN_OUT * 2 * N;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  conv_result_serializer_if #(.N(N), .LEN_OUT(LEN_OUT)) bus ();

  conv_result_serializer #(.N(N), .LEN1(3), .LEN2(50), .SHIFT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] ramp_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < LEN_OUT; i++) f[i*32 +: 32] = 32'(i) << 8;
    return f;
  endfunction

  function automatic logic [FW-1:0] basic_frame();
    logic [FW-1:0] f;
    f = '0;
    f[0 +: 32]  = 32'h0001_2380;
    f[32 +: 32] = 32'hFFFF_FE80;
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
  endtask

  task automatic load(input logic [FW-1:0] f);
    bus.frame_in   = f;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Streams a captured ramp frame from beat 0 with out_ready high.
  task automatic drain_ramp(input string tag);
    bus.out_ready = 1'b1;
    for (int b = 0; b < LEN_OUT; b++) begin
      check({tag, "_data"}, 32'(bus.out_data), 32'(b));
      tick();
    end
    check({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_d;
    int exp_i;
    int lows;

    rst            = 1'b1;
    bus.frame_in   = '0;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Basic frame: 0x00012380 -> 0x0124, 0xFFFFFE80 -> 0xFFFF, rest 0.
    bus.out_ready = 1'b1;
    load(basic_frame());
    for (int b = 0; b < LEN_OUT; b++) begin
      exp_d = (b == 0) ? 16'h0124 : (b == 1) ? 16'hFFFF : 16'h0000;
      check("basic_valid", 32'(bus.out_valid), 32'd1);
      check("basic_load_ready", 32'(bus.load_ready), 32'd0);
      check("basic_data", 32'(bus.out_data), 32'(exp_d));
      check("basic_last", 32'(bus.out_last), 32'(b == LEN_OUT - 1));
      tick();
    end
    check("basic_end_valid", 32'(bus.out_valid), 32'd0);
    check("basic_end_ready", 32'(bus.load_ready), 32'd1);

    // Backpressure with a ramp: sample i requantises to i.
    load(ramp_frame());
    exp_i = 0;
    for (int c = 0; c < 600 && exp_i < LEN_OUT; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'(exp_i));
      check("bp_last", 32'(bus.out_last), 32'(exp_i == LEN_OUT - 1));
      if (bus.out_ready) exp_i++;
      tick();
    end
    check("bp_count", 32'(exp_i), 32'(LEN_OUT));
    check("bp_idle", 32'(bus.out_valid), 32'd0);

    // Saturation / wrap on the two extreme words.
    begin
      logic [FW-1:0] f;
      f = '0;
      f[0 +: 32]  = 32'h7FFF_0000;
      f[32 +: 32] = 32'h8000_0000;
      bus.out_ready = 1'b1;
      load(f);
    end
`ifdef CONV_SAT_EN
    check("sat_hi_data", 32'(bus.out_data), 32'h7FFF);
    check("sat_hi_flag", 32'(bus.sat_flag), 32'd1);
    tick();
    check("sat_lo_data", 32'(bus.out_data), 32'h8000);
    check("sat_lo_flag", 32'(bus.sat_flag), 32'd1);
    tick();
    check("sat_zero_flag", 32'(bus.sat_flag), 32'd0);
`else
    check("wrap_hi_data", 32'(bus.out_data), 32'hFF00);
    tick();
    check("wrap_lo_data", 32'(bus.out_data), 32'h0000);
    tick();
`endif
    for (int c = 0; c < 60 && bus.out_valid; c++) tick();
    check("sat_idle", 32'(bus.load_ready), 32'd1);

    // load_valid held high: 52 busy cycles, one bubble, then recapture.
    bus.frame_in   = ramp_frame();
    bus.load_valid = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    lows = 0;
    for (int c = 0; c < 80 && !bus.load_ready; c++) begin
      lows++;
      tick();
    end
    check("hs_busy_cycles", 32'(lows), 32'd52);
    check("hs_bubble_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("hs_recapture", 32'(bus.load_ready), 32'd0);
    check("hs_restart_data", 32'(bus.out_data), 32'd0);
    bus.load_valid = 1'b0;

    // flush at beat 10 of the recaptured frame.
    for (int b = 0; b < 10; b++) tick();
    check("flush_beat10", 32'(bus.out_data), 32'd10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_ready", 32'(bus.load_ready), 32'd1);

    // flush together with load_valid in IDLE must not capture.
    bus.frame_in   = ramp_frame();
    bus.flush      = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    check("flush_load_valid", 32'(bus.out_valid), 32'd0);
    check("flush_load_ready", 32'(bus.load_ready), 32'd1);

    load(basic_frame());
    check("after_flush_data", 32'(bus.out_data), 32'h0124);
    check("after_flush_last", 32'(bus.out_last), 32'd0);

    // Reset at beat 20, then a clean ramp frame.
    for (int b = 0; b < 20; b++) tick();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    load(ramp_frame());
    drain_ramp("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
